// File: rtl/addr_pkg.sv
// Shared types and helpers for the digit-serial adder addr_seq_ft.
package addr_pkg;

  typedef enum logic [1:0] {IDLE, ADD, CHECK, DONE} state_t;

  // Widest value mod3 can fold. Callers zero-extend their value to this width.
  localparam int MOD3_MAXW = 64;

  // 4 == 1 (mod 3), so summing 2-bit digit pairs preserves the residue.
  function automatic logic [1:0] mod3(input logic [MOD3_MAXW-1:0] v);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < MOD3_MAXW / 2; i++) begin
      acc = acc + {6'b0, v[2*i +: 2]};
    end
    acc = {6'b0, acc[7:6]} + {6'b0, acc[5:4]} + {6'b0, acc[3:2]} + {6'b0, acc[1:0]};
    acc = {6'b0, acc[3:2]} + {6'b0, acc[1:0]};
    acc = {6'b0, acc[3:2]} + {6'b0, acc[1:0]};
    return (acc[1:0] == 2'd3) ? 2'd0 : acc[1:0];
  endfunction

endpackage

// File: rtl/addr_slice.sv
// CHUNK-bit combinational adder slice, time-shared by addr_seq_ft.
module addr_slice #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/addr_seq_ft.sv
// Digit-serial WIDTH-bit adder, CHUNK bits per cycle, with optional mod-3
// residue check enabled by the ADDR_RESIDUE_CHECK_EN macro.
module addr_seq_ft
  import addr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             inj_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             err,
  output logic             busy
);

  localparam int NSLICE = WIDTH / CHUNK;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  generate
    if (CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("addr_seq_ft: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             inj_q, carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   sum_q;
  logic [CHUNK-1:0] sl_a, sl_b, sl_s, sl_w;
  logic             sl_c, last_slice;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready is high only in IDLE; out_valid only in DONE, where sum/err
  // stay frozen until out_ready completes the transfer.
  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign sum        = sum_q;
  assign last_slice = (cnt_q == CW'(NSLICE - 1));

  always_comb begin
    sl_a = a_q[int'(cnt_q)*CHUNK +: CHUNK];
    sl_b = b_q[int'(cnt_q)*CHUNK +: CHUNK];
    sl_w = sl_s;
    sl_w[0] = sl_s[0] ^ (inj_q && (cnt_q == '0));
  end

  addr_slice #(.CHUNK(CHUNK)) u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .s    (sl_s),
    .cout (sl_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (in_valid) state_d = ADD;
`ifdef ADDR_RESIDUE_CHECK_EN
      ADD:   if (last_slice) state_d = CHECK;
`else
      ADD:   if (last_slice) state_d = DONE;
`endif
      CHECK: state_d = DONE;
      DONE:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      inj_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q     <= a;
          b_q     <= b;
          inj_q   <= inj_en;
          carry_q <= 1'b0;
          cnt_q   <= '0;
          sum_q   <= '0;
        end
        ADD: begin
          sum_q[int'(cnt_q)*CHUNK +: CHUNK] <= sl_w;
          carry_q <= sl_c;
          cnt_q   <= cnt_q + 1'b1;
          if (last_slice) sum_q[WIDTH] <= sl_c;
        end
        default: ;
      endcase
    end
  end

`ifdef ADDR_RESIDUE_CHECK_EN
  generate
    if (WIDTH + 1 > MOD3_MAXW) begin : g_bad_width
      $error("addr_seq_ft: residue check supports WIDTH up to 63");
    end
  endgenerate

  logic       err_q;
  logic [1:0] res_a, res_b, res_s, res_ab;
  logic [2:0] res_sum;

  always_comb begin
    res_a   = mod3(MOD3_MAXW'(a_q));
    res_b   = mod3(MOD3_MAXW'(b_q));
    res_s   = mod3(MOD3_MAXW'(sum_q));
    res_sum = {1'b0, res_a} + {1'b0, res_b};
    res_ab  = (res_sum >= 3'd3) ? 2'(res_sum - 3'd3) : res_sum[1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                err_q <= 1'b0;
    else if (state_q == CHECK)                 err_q <= (res_ab != res_s);
    else if (state_q == DONE && out_ready)     err_q <= 1'b0;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_addr_seq_ft.sv
// Randomized self-checking bench for addr_seq_ft (8/2 and 16/4 instances).
module tb_addr_seq_ft;

  localparam int W = 8;
`ifdef ADDR_RESIDUE_CHECK_EN
  localparam int RC = 1;
`else
  localparam int RC = 0;
`endif
  localparam int LAT = 4 + RC;

  logic         clk, rst_n;
  logic         in_valid, in_ready, inj_en, out_valid, out_ready, err, busy;
  logic [W-1:0] a, b;
  logic [W:0]   sum;

  logic         in_valid16, in_ready16, out_valid16, out_ready16, err16, busy16;
  logic [15:0]  a16, b16;
  logic [16:0]  sum16;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W+1:0] exp_q[$];

  addr_seq_ft #(.WIDTH(W), .CHUNK(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .inj_en(inj_en), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .err(err), .busy(busy)
  );

  addr_seq_ft #(.WIDTH(16), .CHUNK(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .inj_en(1'b0), .out_valid(out_valid16),
    .out_ready(out_ready16), .sum(sum16), .err(err16), .busy(busy16)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: true sum, bit 0 flipped by the hook, err from plain % arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input bit inj);
    int s, t;
    logic e;
    t = int'(x) + int'(y);
    s = inj ? (t ^ 1) : t;
    e = (RC == 1) && ((t % 3) != (s % 3));
    return {e, s[W:0]};
  endfunction

  // driver tasks
  task automatic op8(input logic [W-1:0] ta, input logic [W-1:0] tb, input bit tinj,
                     input int hold);
    int n;
    logic [W+1:0] e;
    n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_op", in_ready, 1);
    a = ta; b = tb; inj_en = tinj; in_valid = 1'b1; out_ready = (hold == 0);
    exp_q.push_back(model(ta, tb, tinj));
    @(posedge clk);
    #1;
    in_valid = 1'b0; inj_en = 1'b0;
    a = W'($urandom); b = W'($urandom);
    check("in_ready_after_accept", in_ready, 0);
    check("busy_after_accept", busy, 1);
    n = 0;
    while (out_valid !== 1'b1 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", n, LAT);
    e = exp_q.pop_front();
    check("sum", sum, e[W:0]);
    check("err", err, e[W+1]);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_sum", sum, e[W:0]);
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_busy", busy, 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("post_out_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
    check("post_busy", busy, 0);
    check("post_err", err, 0);
  endtask

  task automatic op16(input logic [15:0] ta, input logic [15:0] tb);
    int n;
    logic [16:0] e;
    e = {1'b0, ta} + {1'b0, tb};
    n = 0;
    while (in_ready16 !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    a16 = ta; b16 = tb; in_valid16 = 1'b1; out_ready16 = 1'b1;
    @(posedge clk);
    #1;
    in_valid16 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom);
    n = 0;
    while (out_valid16 !== 1'b1 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency16", n, LAT);
    check("sum16", sum16, e);
    check("err16", err16, 0);
    @(posedge clk);
    #1;
    check("post_out_valid16", out_valid16, 0);
    out_ready16 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; inj_en = 1'b0; out_ready = 1'b0;
    a = '0; b = '0;
    in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    op8(8'hFF, 8'h01, 1'b0, 0);
    op8(8'hA5, 8'h5A, 1'b0, 0);
    op8(8'h00, 8'h00, 1'b0, 0);
    op8(8'h80, 8'h80, 1'b0, 3);
    op8(8'h03, 8'h04, 1'b1, 0);

    // reset during the second ADD cycle
    @(negedge clk);
    a = 8'h12; b = 8'h34; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", sum, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_rst_out_valid", out_valid, 0);
    op8(8'h12, 8'h34, 1'b0, 0);

    op16(16'hFFFF, 16'hFFFF);
    for (int i = 0; i < 4; i++) op16(16'($urandom), 16'($urandom));

    for (int i = 0; i < 20; i++) begin
      op8(W'($urandom), W'($urandom), ($urandom_range(0, 3) == 0),
          int'($urandom_range(0, 2)));
    end

    // final report
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
